// File: rtl/branch_ctrl_seq.sv
// Conditional-branch control sequencer: drives T3..T6 datapath strobes after the main
// control unit hands over, gates PCin with CON, counts taken/not-taken. Option: BR_FAST_EN.
module branch_ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             CON,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q         <= S_IDLE;
      taken_q         <= 1'b0;
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      taken_q         <= taken_d;
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    taken_d         = taken_q;
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    Gra     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    PCout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ADD     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T3;
      end

      S_T3: begin
        Gra     = 1'b1;
        Rout    = 1'b1;
        CONin   = 1'b1;
        state_d = S_T4;
      end

      S_T4: begin
`ifdef BR_FAST_EN
        // CON is already valid here, so a not-taken branch can retire without
        // computing the target address.
        if (!CON) begin
          done    = 1'b1;
          taken_d = 1'b0;
          if (not_taken_cnt_q != CNT_MAX) not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
          state_d = S_IDLE;
        end else begin
          PCout   = 1'b1;
          Yin     = 1'b1;
          state_d = S_T5;
        end
`else
        PCout   = 1'b1;
        Yin     = 1'b1;
        state_d = S_T5;
`endif
      end

      S_T5: begin
        Cout    = 1'b1;
        ADD     = 1'b1;
        Zin     = 1'b1;
        state_d = S_T6;
      end

      S_T6: begin
        Zlowout = 1'b1;
        PCin    = CON;
        done    = 1'b1;
        taken_d = CON;
        if (CON) begin
          if (taken_cnt_q != CNT_MAX) taken_cnt_d = taken_cnt_q + CNT_ONE;
        end else begin
          if (not_taken_cnt_q != CNT_MAX) not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign taken         = taken_q;
  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

  // PC may only be reloaded while the computed target is on the bus.
  a_pcin_in_t6: assert property (@(posedge clk) disable iff (clr) PCin |-> Zlowout);
  a_done_busy:  assert property (@(posedge clk) disable iff (clr) done |-> busy);

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Directed bench for branch_ctrl_seq (default build): per-cycle vector table for the
// taken / not-taken / ignored-start / clr cases, plus a counter saturation sequence.
module tb_branch_ctrl_seq;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             clr, start, cond;
  logic             con_q = 1'b0;
  logic             Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
  logic             busy, done, taken;
  logic [CNT_W-1:0] taken_cnt, not_taken_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Condition flip-flop of the datapath, loaded by the DUT's CONin strobe.
  always @(posedge clk) if (CONin) con_q <= cond;

  branch_ctrl_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .start(start), .CON(con_q),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin),
    .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
    .busy(busy), .done(done), .taken(taken),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  // Strobe order: Gra Rout CONin PCout Yin Cout ADD Zin Zlowout PCin
  localparam logic [9:0] ST_ID  = 10'b000_00_000_0_0;
  localparam logic [9:0] ST_3   = 10'b111_00_000_0_0;
  localparam logic [9:0] ST_4   = 10'b000_11_000_0_0;
  localparam logic [9:0] ST_5   = 10'b000_00_111_0_0;
  localparam logic [9:0] ST_6T  = 10'b000_00_000_1_1;
  localparam logic [9:0] ST_6N  = 10'b000_00_000_1_0;

  typedef struct {
    logic             clr;
    logic             start;
    logic             cond;
    logic [9:0]       strb;
    logic             busy;
    logic             done;
    logic             taken;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] ntc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic s, input logic cd, input logic [9:0] sb,
                     input logic b, input logic d, input logic t,
                     input logic [CNT_W-1:0] tc, input logic [CNT_W-1:0] ntc);
    vec_t v;
    v.clr = c; v.start = s; v.cond = cd; v.strb = sb;
    v.busy = b; v.done = d; v.taken = t; v.tc = tc; v.ntc = ntc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_inv();
    int groups;
    groups = int'(Gra | Rout | CONin) + int'(PCout | Yin) + int'(Cout | ADD | Zin) + int'(Zlowout);
    chk("one_group", {31'd0, (groups <= 1)}, 32'd1);
    chk("pcin_with_zlowout", {31'd0, (!PCin || Zlowout)}, 32'd1);
  endtask

  logic [9:0] act_strb;
  logic [CNT_W-1:0] exp_tc;
  int lat;
  bit got;

  initial begin
    clr = 1'b1; start = 1'b0; cond = 1'b0;

    //   clr st cd strobe  bsy dn tk tc ntc
    add(0, 0, 0, ST_ID,  0, 0, 0, 0, 0);  // reset state
    add(0, 1, 1, ST_ID,  0, 0, 0, 0, 0);  // taken branch
    add(0, 0, 1, ST_3,   1, 0, 0, 0, 0);
    add(0, 0, 1, ST_4,   1, 0, 0, 0, 0);
    add(0, 0, 1, ST_5,   1, 0, 0, 0, 0);
    add(0, 0, 1, ST_6T,  1, 1, 0, 0, 0);
    add(0, 1, 0, ST_ID,  0, 0, 1, 1, 0);  // not-taken branch
    add(0, 0, 0, ST_3,   1, 0, 1, 1, 0);
    add(0, 0, 1, ST_4,   1, 0, 1, 1, 0);  // cond change after CONin has no effect
    add(0, 0, 1, ST_5,   1, 0, 1, 1, 0);
    add(0, 0, 1, ST_6N,  1, 1, 1, 1, 0);
    add(0, 1, 1, ST_ID,  0, 0, 0, 1, 1);  // start pulsed mid-sequence is ignored
    add(0, 0, 1, ST_3,   1, 0, 0, 1, 1);
    add(0, 1, 0, ST_4,   1, 0, 0, 1, 1);
    add(0, 1, 0, ST_5,   1, 0, 0, 1, 1);
    add(0, 0, 0, ST_6T,  1, 1, 0, 1, 1);
    add(0, 1, 1, ST_ID,  0, 0, 1, 2, 1);  // back-to-back start right after done
    add(0, 0, 1, ST_3,   1, 0, 1, 2, 1);
    add(0, 0, 1, ST_4,   1, 0, 1, 2, 1);
    add(0, 0, 1, ST_5,   1, 0, 1, 2, 1);
    add(0, 0, 1, ST_6T,  1, 1, 1, 2, 1);
    add(0, 1, 1, ST_ID,  0, 0, 1, 3, 1);  // clr mid-sequence
    add(0, 0, 1, ST_3,   1, 0, 1, 3, 1);
    add(0, 0, 1, ST_4,   1, 0, 1, 3, 1);
    add(1, 0, 1, ST_5,   1, 0, 1, 3, 1);
    add(1, 1, 1, ST_ID,  0, 0, 0, 0, 0);  // clr beats start
    add(0, 0, 0, ST_ID,  0, 0, 0, 0, 0);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      clr = tbl[i].clr; start = tbl[i].start; cond = tbl[i].cond;
      #1;
      act_strb = {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin};
      chk($sformatf("vec%0d", i),
          {15'd0, act_strb, busy, done, taken, taken_cnt, not_taken_cnt},
          {15'd0, tbl[i].strb, tbl[i].busy, tbl[i].done, tbl[i].taken, tbl[i].tc, tbl[i].ntc});
      check_inv();
    end

    // Five taken branches: latency 4 each, taken_cnt saturates at 3.
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      clr = 1'b0; start = 1'b1; cond = 1'b1;
      #1; check_inv();
      lat = 0; got = 0;
      for (int c = 1; c <= 8 && !got; c++) begin
        @(negedge clk);
        start = 1'b0;
        #1; check_inv();
        if (done) begin
          got = 1; lat = c;
          chk($sformatf("sat%0d_pcin", b), {31'd0, PCin}, 32'd1);
        end
      end
      chk($sformatf("sat%0d_latency", b), lat, 32'd4);
      @(negedge clk);
      #1; check_inv();
      exp_tc = (b >= 2) ? 2'd3 : 2'(b + 1);
      chk($sformatf("sat%0d_taken_cnt", b), {30'd0, taken_cnt}, {30'd0, exp_tc});
      chk($sformatf("sat%0d_not_taken_cnt", b), {30'd0, not_taken_cnt}, 32'd0);
      chk($sformatf("sat%0d_taken", b), {31'd0, taken}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
